fix_msg_framer: RTL and testbench
=================================

// Module: fix_msg_framer
// PURPOSE
//  Transmit-side FIX framer feeding the outbound byte FIFO (same message_o / send_message_valid_o stream the engine drives).
//  Buffers one application message body, then emits a complete frame: "8=FIX.4.2<SOH>9=<len><SOH><body>10=<ccc><SOH>".
//  Computes BodyLength (tag 9) and CheckSum (tag 10) in hardware so the app only supplies tag 35 onward. SOH = 8'h01.
// PARAMETERS
//  BUF_DEPTH  256  max body bytes buffered per message (1..999; sets tag-9 digit count, up to 3 digits)
//  AW         8    body buffer address width, >= clog2(BUF_DEPTH); length counter is AW+1 bits
// PORTS
//  clk                   in   1  clock, rising edge
//  rst                   in   1  asynchronous, active-low reset (0 = reset)
//  body_i                in   8  body byte from app (app supplies the SOH after each field, incl. the last)
//  body_valid_i          in   1  body_i valid
//  body_last_i           in   1  qualifies final body byte of the message
//  body_ready_o          out  1  framer accepts body byte (transfer = valid & ready)
//  message_o             out  8  framed byte to outbound FIFO
//  send_message_valid_o  out  1  message_o valid
//  fifo_ready_i          in   1  FIFO accepts byte (transfer = valid & ready)
//  busy_o                out  1  high in any state other than IDLE/LOAD
//  overflow_o            out  1  one-cycle pulse: body exceeded BUF_DEPTH, message dropped
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, counters/checksum=0, body_ready_o=0, send_message_valid_o=0,
//   message_o=8'h00, busy_o=0, overflow_o=0. Partial message in flight is discarded; no frame fragment continues.
//  States: IDLE -> LOAD -> HDR_BEGIN -> HDR_LEN -> BODY -> TRAILER -> IDLE.
//  IDLE: body_ready_o=1 from first cycle after reset release; first accepted byte -> LOAD (byte stored at addr 0).
//  LOAD: body_ready_o=1; each accepted byte stored, len++. Byte accepted with body_last_i -> HDR_BEGIN next cycle.
//   Accepting byte number BUF_DEPTH+1 without last: byte dropped, overflow_o=1 for one cycle, -> IDLE, nothing emitted.
//   Byte with last exactly at count BUF_DEPTH is legal.
//  body_ready_o=0 in HDR_BEGIN..TRAILER; next body accepted only once back in IDLE (cycle after trailer SOH transfer).
//  Latency: first frame byte '8' valid on cycle after last body byte accepted.
//  HDR_BEGIN: 10 fixed bytes "8=FIX.4.2<SOH>". HDR_LEN: '9','=', decimal len w/o leading zeros (1-3 digits), SOH.
//  BODY: buffered bytes addr 0..len-1 in order. TRAILER: '1','0','=', 3 checksum digits WITH leading zeros, SOH.
//  Output handshake: send_message_valid_o held high continuously from '8' through trailer SOH; message_o stable while
//   valid & !fifo_ready_i; advance one byte per cycle when fifo_ready_i=1 (full-throughput, no bubbles).
//  Checksum: 8-bit wrapping sum of every byte emitted from '8' through the SOH ending the body (excludes "10=" field);
//   accumulated on each output transfer; cleared on entry to HDR_BEGIN.
//  Decimal conversion: len and checksum to ASCII ('0'+digit); conversion may be combinational or pipelined but must
//   not add latency beyond that stated above.
//  busy_o=1 from HDR_BEGIN entry through trailer SOH transfer cycle.
//  Simultaneous: fifo_ready_i toggling every cycle must not skip/duplicate bytes; body_valid_i while busy ignored.
// TESTING
//  1 Reset: rst=0 mid-BODY emission -> all outputs 0 same cycle; after release body_ready_o=1, next frame starts clean.
//  2 Body "35=0<SOH>" (5B), fifo_ready_i=1 -> exact 26-byte stream "8=FIX.4.2<SOH>9=5<SOH>35=0<SOH>10=161<SOH>",
//    '8' one cycle after last, valid never drops.
//  3 Same body, fifo_ready_i random 50% -> identical byte sequence; message_o stable during every stall.
//  4 Body of BUF_DEPTH=256 bytes with last on byte 256 -> tag 9 = "256", checksum matches model; 257th byte w/o last
//    -> overflow_o one-cycle pulse, no send_message_valid_o, back to IDLE.
//  5 Checksum with leading zeros: body chosen so sum mod 256 = 7 -> trailer "10=007<SOH>".
//  6 Back-to-back: app holds body_valid_i during frame -> body_ready_o=0 until IDLE; second frame follows correctly.

Source files
------------

// File: rtl/fix_msg_framer.sv
// Transmit-side FIX framer: buffers one application body, then emits
// "8=FIX.4.2|9=<len>|<body>10=<ccc>|" with BodyLength and CheckSum generated here.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for first body byte (stored at addr 0)
// S_LOAD      | buffering body bytes until last or overflow
// S_HDR_BEGIN | emitting "8=FIX.4.2<SOH>"
// S_HDR_LEN   | emitting "9=", decimal body length, SOH
// S_BODY      | emitting buffered body bytes in order
// S_TRAILER   | emitting "10=", three checksum digits, SOH

module fix_msg_framer #(
    parameter int BUF_DEPTH = 256,
    parameter int AW        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] body_i,
    input  logic       body_valid_i,
    input  logic       body_last_i,
    output logic       body_ready_o,
    output logic [7:0] message_o,
    output logic       send_message_valid_o,
    input  logic       fifo_ready_i,
    output logic       busy_o,
    output logic       overflow_o
);

    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HDR_BEGIN,
        S_HDR_LEN,
        S_BODY,
        S_TRAILER
    } state_t;

    state_t          state, state_nxt;
    logic [LW-1:0]   len;
    logic [LW-1:0]   idx;
    logic [7:0]      csum;
    logic            ready_q;
    logic            ovf_q;
    logic [7:0]      mem [0:(1<<AW)-1];

    logic            accept;
    logic            xfer;
    logic            ovf_hit;
    logic            seg_done;
    logic [15:0]     len_w;
    logic [15:0]     ck_w;
    logic [1:0]      nd;
    logic [2:0]      len_last_idx;
    logic [1:0]      dpos;
    logic [7:0]      len_h, len_t, len_o;
    logic [7:0]      ck_h, ck_t, ck_o;

    function automatic logic [7:0] ascii(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    assign accept  = body_valid_i & ready_q;
    assign xfer    = send_message_valid_o & fifo_ready_i;
    assign ovf_hit = accept && (state == S_LOAD) && (len == LW'(BUF_DEPTH));

    assign len_w = 16'(len);
    assign ck_w  = {8'h00, csum};
    assign len_h = ascii(4'(len_w / 16'd100));
    assign len_t = ascii(4'((len_w / 16'd10) % 16'd10));
    assign len_o = ascii(4'(len_w % 16'd10));
    assign ck_h  = ascii(4'(ck_w / 16'd100));
    assign ck_t  = ascii(4'((ck_w / 16'd10) % 16'd10));
    assign ck_o  = ascii(4'(ck_w % 16'd10));

    // Length is printed without leading zeros; dpos maps the digit slot to H/T/O.
    assign nd           = (len_w >= 16'd100) ? 2'd3 : (len_w >= 16'd10) ? 2'd2 : 2'd1;
    assign len_last_idx = 3'd2 + {1'b0, nd};
    assign dpos         = idx[1:0] + 2'd1 - nd;

    always_comb begin
        state_nxt            = state;
        message_o            = 8'h00;
        send_message_valid_o = 1'b0;
        seg_done             = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = body_last_i ? S_HDR_BEGIN : S_LOAD;
            end
            S_LOAD: begin
                if (ovf_hit)                    state_nxt = S_IDLE;
                else if (accept && body_last_i) state_nxt = S_HDR_BEGIN;
            end
            S_HDR_BEGIN: begin
                send_message_valid_o = 1'b1;
                case (idx[3:0])
                    4'd0:    message_o = 8'h38;
                    4'd1:    message_o = 8'h3D;
                    4'd2:    message_o = 8'h46;
                    4'd3:    message_o = 8'h49;
                    4'd4:    message_o = 8'h58;
                    4'd5:    message_o = 8'h2E;
                    4'd6:    message_o = 8'h34;
                    4'd7:    message_o = 8'h2E;
                    4'd8:    message_o = 8'h32;
                    default: message_o = 8'h01;
                endcase
                seg_done = (idx == LW'(9));
                if (xfer && seg_done) state_nxt = S_HDR_LEN;
            end
            S_HDR_LEN: begin
                send_message_valid_o = 1'b1;
                seg_done = (idx == LW'(len_last_idx));
                if (idx == LW'(0))      message_o = 8'h39;
                else if (idx == LW'(1)) message_o = 8'h3D;
                else if (seg_done)      message_o = 8'h01;
                else begin
                    case (dpos)
                        2'd0:    message_o = len_h;
                        2'd1:    message_o = len_t;
                        default: message_o = len_o;
                    endcase
                end
                if (xfer && seg_done) state_nxt = S_BODY;
            end
            S_BODY: begin
                send_message_valid_o = 1'b1;
                message_o = mem[idx[AW-1:0]];
                seg_done  = (idx == len - LW'(1));
                if (xfer && seg_done) state_nxt = S_TRAILER;
            end
            S_TRAILER: begin
                send_message_valid_o = 1'b1;
                case (idx[2:0])
                    3'd0:    message_o = 8'h31;
                    3'd1:    message_o = 8'h30;
                    3'd2:    message_o = 8'h3D;
                    3'd3:    message_o = ck_h;
                    3'd4:    message_o = ck_t;
                    3'd5:    message_o = ck_o;
                    default: message_o = 8'h01;
                endcase
                seg_done = (idx == LW'(6));
                if (xfer && seg_done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            len     <= '0;
            idx     <= '0;
            csum    <= 8'h00;
            ready_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == S_IDLE) || (state_nxt == S_LOAD);
            ovf_q   <= ovf_hit;
            if (state_nxt != state) idx <= '0;
            else if (xfer)          idx <= idx + LW'(1);
            if (accept && state == S_IDLE)              len <= LW'(1);
            else if (accept && state == S_LOAD && !ovf_hit) len <= len + LW'(1);
            // Trailer digits are taken from csum, so it must freeze once "10=" starts.
            if (state_nxt == S_HDR_BEGIN && state != S_HDR_BEGIN) csum <= 8'h00;
            else if (xfer && state != S_TRAILER)                  csum <= csum + message_o;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !ovf_hit)
            mem[(state == S_IDLE) ? '0 : len[AW-1:0]] <= body_i;
    end

    assign body_ready_o = ready_q;
    assign busy_o       = send_message_valid_o;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_fix_msg_framer.sv
// Bench for fix_msg_framer: random bodies, random FIFO back-pressure, frames
// compared against a string-built reference frame.

module tb_fix_msg_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] body_i = 8'h00;
    logic       body_valid_i = 1'b0;
    logic       body_last_i = 1'b0;
    logic       body_ready_o;
    logic [7:0] message_o;
    logic       send_message_valid_o;
    logic       fifo_ready_i = 1'b1;
    logic       busy_o;
    logic       overflow_o;

    fix_msg_framer dut (
        .clk                  (clk),
        .rst                  (rst),
        .body_i               (body_i),
        .body_valid_i         (body_valid_i),
        .body_last_i          (body_last_i),
        .body_ready_o         (body_ready_o),
        .message_o            (message_o),
        .send_message_valid_o (send_message_valid_o),
        .fifo_ready_i         (fifo_ready_i),
        .busy_o               (busy_o),
        .overflow_o           (overflow_o)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    logic [7:0] body_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int drops, stallbad, rdybad, valid_seen, drv_left;
    bit end_ok, lat;

    // Reference frame from the textual format; checksum is the plain byte sum mod 256.
    task automatic model_frame();
        string s;
        int sum;
        exp_q.delete();
        s = $sformatf("8=FIX.4.2\0019=%0d\001", body_q.size());
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        foreach (body_q[i]) exp_q.push_back(body_q[i]);
        sum = 0;
        foreach (exp_q[i]) sum += int'(exp_q[i]);
        s = $sformatf("10=%03d\001", sum % 256);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic rand_body(input int n);
        body_q.delete();
        for (int i = 0; i < n; i++) body_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Called and returns at a negedge; ready sampled before the edge decides acceptance.
    task automatic drive_body(input int n, input bit use_last);
        int i;
        int guard;
        bit acc;
        i = 0; guard = 0; valid_seen = 0;
        while (i < n && guard < 4000) begin
            body_i       = body_q[i];
            body_valid_i = 1'b1;
            body_last_i  = use_last && (i == n - 1);
            acc          = body_ready_o;
            if (send_message_valid_o === 1'b1) valid_seen++;
            @(negedge clk);
            if (acc) i++;
            guard++;
        end
        body_valid_i = 1'b0;
        body_last_i  = 1'b0;
        drv_left     = n - i;
        lat = (send_message_valid_o === 1'b1) && (message_o === 8'h38);
    endtask

    task automatic collect(input bit rnd);
        bit fr;
        bit prev_stall;
        logic [7:0] prev_msg;
        int cyc;
        prev_stall = 1'b0; prev_msg = 8'h00; cyc = 0;
        drops = 0; stallbad = 0; rdybad = 0;
        got_q.delete();
        while (got_q.size() < exp_q.size() && cyc < 4000) begin
            if (send_message_valid_o !== 1'b1) drops++;
            if (prev_stall && message_o !== prev_msg) stallbad++;
            if (body_ready_o !== 1'b0) rdybad++;
            fr = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            fifo_ready_i = fr;
            if (fr && send_message_valid_o === 1'b1) got_q.push_back(message_o);
            prev_stall = !fr;
            prev_msg   = message_o;
            cyc++;
            @(negedge clk);
        end
        fifo_ready_i = 1'b1;
        end_ok = (send_message_valid_o === 1'b0) && (busy_o === 1'b0) && (body_ready_o === 1'b1);
    endtask

    task automatic test_reset();
        @(negedge clk);
        nvec++;
        if ({body_ready_o, send_message_valid_o, message_o, busy_o, overflow_o} !== 12'h000) begin
            nerr++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b msg=%h busy=%b ovf=%b want all 0",
                     body_ready_o, send_message_valid_o, message_o, busy_o, overflow_o);
        end
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if (body_ready_o !== 1'b1 || send_message_valid_o !== 1'b0) begin
            nerr++;
            $display("FAIL reset_release: got rdy=%b vld=%b want rdy=1 vld=0", body_ready_o, send_message_valid_o);
        end
    endtask

    task automatic test_basic();
        string s;
        s = "8=FIX.4.2\0019=5\00135=0\00110=161\001";
        body_q.delete();
        body_q.push_back(8'h33); body_q.push_back(8'h35); body_q.push_back(8'h3D);
        body_q.push_back(8'h30); body_q.push_back(8'h01);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        drive_body(5, 1'b1);
        nvec++;
        if (!lat) begin nerr++; $display("FAIL basic_latency: got vld=%b msg=%h want 1/38", send_message_valid_o, message_o); end
        collect(1'b0);
        nvec++;
        if (drops != 0 || rdybad != 0) begin nerr++; $display("FAIL basic_handshake: got drops=%0d rdybad=%0d want 0/0", drops, rdybad); end
        nvec++;
        if (got_q.size() != 26) begin nerr++; $display("FAIL basic_len: got %0d want 26", got_q.size()); end
        foreach (exp_q[i]) begin
            nvec++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL basic_byte %0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        nvec++;
        if (!end_ok) begin nerr++; $display("FAIL basic_idle: got vld=%b busy=%b rdy=%b want 0/0/1", send_message_valid_o, busy_o, body_ready_o); end
    endtask

    task automatic test_random_stall();
        body_q.delete();
        body_q.push_back(8'h33); body_q.push_back(8'h35); body_q.push_back(8'h3D);
        body_q.push_back(8'h30); body_q.push_back(8'h01);
        model_frame();
        drive_body(5, 1'b1);
        nvec++;
        if (!lat) begin nerr++; $display("FAIL stall_latency: got vld=%b msg=%h want 1/38", send_message_valid_o, message_o); end
        collect(1'b1);
        nvec++;
        if (drops != 0 || stallbad != 0 || rdybad != 0) begin
            nerr++; $display("FAIL stall_handshake: got drops=%0d stallbad=%0d rdybad=%0d want 0", drops, stallbad, rdybad);
        end
        foreach (exp_q[i]) begin
            nvec++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL stall_byte %0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        nvec++;
        if (!end_ok) begin nerr++; $display("FAIL stall_idle: got vld=%b busy=%b rdy=%b want 0/0/1", send_message_valid_o, busy_o, body_ready_o); end
    endtask

    task automatic test_max();
        rand_body(256);
        model_frame();
        drive_body(256, 1'b1);
        nvec++;
        if (!lat || drv_left != 0) begin nerr++; $display("FAIL max_latency: got vld=%b left=%0d want 1/0", send_message_valid_o, drv_left); end
        collect(1'b1);
        nvec++;
        if (drops != 0 || stallbad != 0 || rdybad != 0) begin
            nerr++; $display("FAIL max_handshake: got drops=%0d stallbad=%0d rdybad=%0d want 0", drops, stallbad, rdybad);
        end
        nvec++;
        if (got_q.size() < 15 || got_q[12] !== 8'h32 || got_q[13] !== 8'h35 || got_q[14] !== 8'h36) begin
            nerr++; $display("FAIL max_tag9: got size=%0d want digits 256", got_q.size());
        end
        foreach (exp_q[i]) begin
            nvec++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL max_byte %0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        nvec++;
        if (!end_ok) begin nerr++; $display("FAIL max_idle: got vld=%b busy=%b rdy=%b want 0/0/1", send_message_valid_o, busy_o, body_ready_o); end
    endtask

    task automatic test_overflow();
        rand_body(257);
        drive_body(257, 1'b0);
        nvec++;
        if (overflow_o !== 1'b1 || send_message_valid_o !== 1'b0 || valid_seen != 0 || drv_left != 0) begin
            nerr++;
            $display("FAIL ovf_pulse: got ovf=%b vld=%b vseen=%0d left=%0d want 1/0/0/0",
                     overflow_o, send_message_valid_o, valid_seen, drv_left);
        end
        @(negedge clk);
        nvec++;
        if (overflow_o !== 1'b0 || send_message_valid_o !== 1'b0 || body_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            nerr++;
            $display("FAIL ovf_after: got ovf=%b vld=%b rdy=%b busy=%b want 0/0/1/0",
                     overflow_o, send_message_valid_o, body_ready_o, busy_o);
        end
    endtask

    task automatic test_csum_zero();
        int sum;
        body_q.delete();
        body_q.push_back(8'h33); body_q.push_back(8'h35); body_q.push_back(8'h3D);
        body_q.push_back(8'h00); body_q.push_back(8'h01);
        model_frame();
        sum = 0;
        for (int i = 0; i < exp_q.size() - 7; i++) sum += int'(exp_q[i]);
        body_q[3] = 8'((7 - sum) & 255);
        model_frame();
        drive_body(5, 1'b1);
        collect(1'b1);
        nvec++;
        if (got_q.size() != exp_q.size() || got_q[got_q.size()-4] !== 8'h30 ||
            got_q[got_q.size()-3] !== 8'h30 || got_q[got_q.size()-2] !== 8'h37) begin
            nerr++; $display("FAIL csum007: got size=%0d want trailer 10=007", got_q.size());
        end
        foreach (exp_q[i]) begin
            nvec++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL csum_byte %0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] body2[$];
        rand_body(9);
        body2 = body_q;
        rand_body(12);
        model_frame();
        drive_body(12, 1'b1);
        body_i       = body2[0];
        body_valid_i = 1'b1;
        collect(1'b1);
        nvec++;
        if (rdybad != 0 || drops != 0) begin nerr++; $display("FAIL b2b_ready_low: got rdybad=%0d drops=%0d want 0/0", rdybad, drops); end
        foreach (exp_q[i]) begin
            nvec++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL b2b_first_byte %0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        body_q = body2;
        model_frame();
        drive_body(9, 1'b1);
        nvec++;
        if (!lat) begin nerr++; $display("FAIL b2b_latency: got vld=%b msg=%h want 1/38", send_message_valid_o, message_o); end
        collect(1'b0);
        foreach (exp_q[i]) begin
            nvec++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL b2b_second_byte %0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        nvec++;
        if (!end_ok) begin nerr++; $display("FAIL b2b_idle: got vld=%b busy=%b rdy=%b want 0/0/1", send_message_valid_o, busy_o, body_ready_o); end
    endtask

    task automatic test_reset_mid();
        rand_body(20);
        drive_body(20, 1'b1);
        fifo_ready_i = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        nvec++;
        if ({body_ready_o, send_message_valid_o, message_o, busy_o, overflow_o} !== 12'h000) begin
            nerr++;
            $display("FAIL midreset_outputs: got rdy=%b vld=%b msg=%h busy=%b ovf=%b want all 0",
                     body_ready_o, send_message_valid_o, message_o, busy_o, overflow_o);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if (body_ready_o !== 1'b1 || send_message_valid_o !== 1'b0) begin
            nerr++; $display("FAIL midreset_release: got rdy=%b vld=%b want 1/0", body_ready_o, send_message_valid_o);
        end
        rand_body(7);
        model_frame();
        drive_body(7, 1'b1);
        collect(1'b1);
        foreach (exp_q[i]) begin
            nvec++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL midreset_byte %0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        nvec++;
        if (!end_ok) begin nerr++; $display("FAIL midreset_idle: got vld=%b busy=%b rdy=%b want 0/0/1", send_message_valid_o, busy_o, body_ready_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_stall();
        test_max();
        test_overflow();
        test_csum_zero();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
